// File: rtl/mlp_layer_sequencer_if.sv
// Control/config and stage-1 output bundle of the MLP layer sequencer.
interface mlp_layer_sequencer_if #(
    parameter int unsigned NADDR_W = 12,
    parameter int unsigned WADDR_W = 16
);
    logic               run;
    logic               start;
    logic [NADDR_W-1:0] num_inputs;
    logic [NADDR_W-1:0] num_outputs;
    logic [NADDR_W-1:0] in_base;
    logic [NADDR_W-1:0] out_base;
    logic [WADDR_W-1:0] weight_base;

    logic               done_1;
    logic [NADDR_W-1:0] neuron_addr_1;
    logic [WADDR_W-1:0] weight_addr_1;
    logic               reset_mult_acc_1;
    logic [NADDR_W-1:0] out_neuron_addr_1;
    logic               write_neuron_1;

    // Controller side: issues requests and config, observes stage-1 outputs
    modport master (
        output run, start, num_inputs, num_outputs, in_base, out_base, weight_base,
        input  done_1, neuron_addr_1, weight_addr_1, reset_mult_acc_1,
               out_neuron_addr_1, write_neuron_1
    );

    // Sequencer side
    modport slave (
        input  run, start, num_inputs, num_outputs, in_base, out_base, weight_base,
        output done_1, neuron_addr_1, weight_addr_1, reset_mult_acc_1,
               out_neuron_addr_1, write_neuron_1
    );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// Stage-1 address/control generator for one fully connected MLP layer.
// Outputs are registered and reflect the state entered on the last edge,
// so the first MAC beat is visible the cycle after start is sampled.
module mlp_layer_sequencer #(
    parameter int unsigned NADDR_W = 12,
    parameter int unsigned WADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mlp_layer_sequencer_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MAC   = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [NADDR_W-1:0] i_q, i_d;
    logic [NADDR_W-1:0] j_q, j_d;
    logic [NADDR_W-1:0] ni_q, ni_d;
    logic [NADDR_W-1:0] no_q, no_d;
    logic [NADDR_W-1:0] in_base_q, in_base_d;
    logic [NADDR_W-1:0] out_base_q, out_base_d;
    logic               done_q, done_d;
    logic [NADDR_W-1:0] naddr_q, naddr_d;
    logic [WADDR_W-1:0] waddr_q, waddr_d;
    logic               rma_q, rma_d;
    logic [NADDR_W-1:0] oaddr_q, oaddr_d;
    logic               wr_q, wr_d;

    // Next state, counters and next registered outputs; weight_addr doubles as the weight counter
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        ni_d       = ni_q;
        no_d       = no_q;
        in_base_d  = in_base_q;
        out_base_d = out_base_q;
        done_d     = done_q;
        naddr_d    = naddr_q;
        waddr_d    = waddr_q;
        oaddr_d    = oaddr_q;
        rma_d      = 1'b0;
        wr_d       = 1'b0;

        if (!bus.run) begin
            state_d = ST_IDLE;
            i_d     = '0;
            j_d     = '0;
            done_d  = 1'b0;
            naddr_d = '0;
            waddr_d = '0;
            oaddr_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        ni_d       = bus.num_inputs;
                        no_d       = bus.num_outputs;
                        in_base_d  = bus.in_base;
                        out_base_d = bus.out_base;
                        i_d        = '0;
                        j_d        = '0;
                        if ((bus.num_inputs == '0) || (bus.num_outputs == '0)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_MAC;
                            done_d  = 1'b0;
                            naddr_d = bus.in_base;
                            waddr_d = bus.weight_base;
                            rma_d   = 1'b1;
                        end
                    end
                end
                ST_MAC: begin
                    if (i_q == NADDR_W'(ni_q - NADDR_W'(1))) begin
                        state_d = ST_WRITE;
                        wr_d    = 1'b1;
                        oaddr_d = NADDR_W'(out_base_q + j_q);
                    end else begin
                        i_d     = NADDR_W'(i_q + NADDR_W'(1));
                        naddr_d = NADDR_W'(in_base_q + i_q + NADDR_W'(1));
                        waddr_d = WADDR_W'(waddr_q + WADDR_W'(1));
                    end
                end
                ST_WRITE: begin
                    if (j_q == NADDR_W'(no_q - NADDR_W'(1))) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_MAC;
                        j_d     = NADDR_W'(j_q + NADDR_W'(1));
                        i_d     = '0;
                        naddr_d = in_base_q;
                        waddr_d = WADDR_W'(waddr_q + WADDR_W'(1));
                        rma_d   = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, counters, latched config and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            ni_q       <= '0;
            no_q       <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
            done_q     <= 1'b0;
            naddr_q    <= '0;
            waddr_q    <= '0;
            rma_q      <= 1'b0;
            oaddr_q    <= '0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            ni_q       <= ni_d;
            no_q       <= no_d;
            in_base_q  <= in_base_d;
            out_base_q <= out_base_d;
            done_q     <= done_d;
            naddr_q    <= naddr_d;
            waddr_q    <= waddr_d;
            rma_q      <= rma_d;
            oaddr_q    <= oaddr_d;
            wr_q       <= wr_d;
        end
    end

    assign bus.done_1            = done_q;
    assign bus.neuron_addr_1     = naddr_q;
    assign bus.weight_addr_1     = waddr_q;
    assign bus.reset_mult_acc_1  = rma_q;
    assign bus.out_neuron_addr_1 = oaddr_q;
    assign bus.write_neuron_1    = wr_q;
endmodule

// File: doc/mlp_layer_sequencer.md
Name: mlp_layer_sequencer

Overview:
- Stage-1 address/control generator for one fully connected MLP layer.
- Produces neuron_addr, weight_addr, reset_mult_acc, out_neuron_addr, write_neuron and done.
- Outputs feed the stage-1→stage-2 pipeline buffer. Downstream stages perform the memory reads, multiply-accumulate and neuron write-back.
- One invocation walks every output neuron. For each output neuron it steps through all input neurons, then issues a single write-back cycle.

Parameters:
- NADDR_W, 12, width of neuron addresses and of the input/output count ports.
- WADDR_W, 16, width of weight addresses.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  global enable; low forces a synchronous return to IDLE.
- start  input  1  single-cycle request to process a layer; sampled only in IDLE or DONE.
- num_inputs  input  NADDR_W  input neurons per output neuron; latched at start.
- num_outputs  input  NADDR_W  output neurons in the layer; latched at start.
- in_base  input  NADDR_W  first input-neuron address; latched at start.
- out_base  input  NADDR_W  first output-neuron address; latched at start.
- weight_base  input  WADDR_W  first weight address; latched at start.
- done_1  output  1  layer complete, level.
- neuron_addr_1  output  NADDR_W  input-neuron read address.
- weight_addr_1  output  WADDR_W  weight read address.
- reset_mult_acc_1  output  1  clear accumulator on this MAC beat.
- out_neuron_addr_1  output  NADDR_W  write-back address.
- write_neuron_1  output  1  write-back strobe.

Behaviour:
- All outputs are registered. Reset (rst_n low, asynchronous) forces every output to 0, state to IDLE, and all counters and latched config to 0.
- States are IDLE, MAC, WRITE, DONE.
- IDLE: all outputs 0.
  - If run=1 and start=1: latch config, set i=0, j=0, weight counter=weight_base.
  - Next state is MAC, or DONE if num_inputs==0 or num_outputs==0.
- MAC (one beat per cycle, first beat the cycle after start):
  - neuron_addr_1 = in_base+i, mod 2^NADDR_W.
  - weight_addr_1 = weight counter.
  - reset_mult_acc_1 = 1 only when i==0.
  - write_neuron_1 = 0.
  - Weight counter increments every MAC beat, mod 2^WADDR_W. It is never reset between output neurons, so weights are contiguous row-major (j*num_inputs+i).
  - When i==num_inputs-1: go to WRITE; otherwise i++.
- WRITE (exactly one cycle):
  - write_neuron_1 = 1, out_neuron_addr_1 = out_base+j, mod 2^NADDR_W.
  - reset_mult_acc_1 = 0; neuron_addr_1 and weight_addr_1 hold their last MAC values.
  - If j==num_outputs-1: go to DONE; else j++, i=0, go to MAC.
- DONE:
  - done_1 = 1 (held); write_neuron_1 = 0, reset_mult_acc_1 = 0; address outputs hold.
  - start=1 with run=1: relatch config and restart as from IDLE; done_1 drops in the same cycle the first MAC beat appears.
- run=0 in any state, including mid-layer: next edge goes to IDLE with all outputs 0; the partial layer is abandoned.
- start while in MAC or WRITE is ignored. Config inputs are don't-care after the start cycle.
- Total cycles from start to done_1 rising = num_outputs*(num_inputs+1)+1.

Test Plan:
- Basic layer: num_inputs=3, num_outputs=2, in_base=0x010, out_base=0x100, weight_base=0x0200, start pulse → required sequence:
  - (n=0x010, w=0x200, rma=1)
  - (0x011, 0x201, 0)
  - (0x012, 0x202, 0)
  - write=1 out=0x100
  - (0x010, 0x203, 1)
  - (0x011, 0x204, 0)
  - (0x012, 0x205, 0)
  - write=1 out=0x101
  - done_1=1 on the 9th cycle after start, held.
- Wrap: in_base=0xFFF, weight_base=0xFFFF, num_inputs=2, num_outputs=1 → neuron_addr 0xFFF then 0x000; weight_addr 0xFFFF then 0x0000.
- Zero size: num_outputs=0, start → no MAC or WRITE beats; done_1=1 one cycle after start.
- Abort: drop run during the 2nd MAC beat of the basic layer → all outputs 0 next cycle, IDLE. A fresh start then replays the basic sequence from weight 0x200.
- Async reset: assert rst_n low mid-WRITE, between clock edges → outputs 0 immediately. Start ignored while rst_n is low.
- Restart from DONE with different config (num_inputs=1, num_outputs=1, weight_base=0x0050) → done_1 falls as the first beat (w=0x050, rma=1) appears; done_1 rises again 3 cycles after start.
